// File: rtl/sar_ctrl_param.sv
// sar_ctrl_param: parametrised SAR ADC conversion controller driving comparator clock, CDAC sample and reference switches
// All outputs are registered from the next-state values so they change cleanly on the CLK edge.
module sar_ctrl_param #(
    parameter int N_BITS   = 8,
    parameter int PH_CYC   = 1,
    parameter int SAMP_CYC = 2
) (
    input  logic              CLK,
    input  logic              XRST,
    input  logic              START,
    input  logic              CONT_MODE,
    input  logic              COMP_OUT,
    output logic              COMP_CLK,
    output logic              SC,
    output logic [N_BITS:0]   SDAC,
    output logic              DOUT_SER,
    output logic              DOUT_SER_VLD,
    output logic [N_BITS-1:0] RESULT,
    output logic              RESULT_VLD,
    input  logic              RESULT_RDY,
    output logic              BUSY,
    output logic              OVERRUN
);
    localparam int MAXC = (PH_CYC > SAMP_CYC) ? PH_CYC : SAMP_CYC;
    localparam int PW = $clog2(MAXC) + 1;
    localparam logic [N_BITS:0] LSB1 = {{N_BITS{1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, SAMPLE, HOLD, DAC, COMP, DECIDE} state_t;

    state_t state, state_nx;
    logic [PW-1:0] ph_cnt;
    logic [3:0] bit_cnt;
    logic last, dec_edge, lsb_edge, dac_entry, sc_nx, comp_clk_nx;
    logic [N_BITS:0] sdac_nx, cur_mask, new_mask;
    logic [N_BITS-1:0] code;

    assign last      = ph_cnt == PW'((state == SAMPLE ? SAMP_CYC : PH_CYC) - 1);
    assign dec_edge  = state == DECIDE && last;
    assign lsb_edge  = dec_edge && bit_cnt == 4'd0;
    assign dac_entry = state_nx == DAC && state != DAC;
    // SDAC[k+1] carries trial bit k; index 0 is the termination cap and never set
    assign cur_mask  = LSB1 << ({1'b0, bit_cnt} + 5'd1);
    assign new_mask  = state == HOLD ? LSB1 << N_BITS : LSB1 << bit_cnt;
    assign code      = {SDAC[N_BITS:2], COMP_OUT};
    assign sdac_nx   = lsb_edge ? '0 :
                       (((dec_edge && !COMP_OUT) ? SDAC & ~cur_mask : SDAC) | (dac_entry ? new_mask : '0));

    always_ff @(posedge CLK or negedge XRST) begin
        if (!XRST) begin
            state   <= IDLE;
            ph_cnt  <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_nx;
            ph_cnt  <= (state == IDLE || last) ? '0 : ph_cnt + 1'b1;
            bit_cnt <= state == HOLD ? 4'(N_BITS - 1) : (dec_edge && !lsb_edge) ? bit_cnt - 4'd1 : bit_cnt;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (START) state_nx = SAMPLE;
            SAMPLE:  if (last) state_nx = HOLD;
            HOLD:    if (last) state_nx = DAC;
            DAC:     if (last) state_nx = COMP;
            COMP:    if (last) state_nx = DECIDE;
            DECIDE:  if (last) state_nx = bit_cnt != 4'd0 ? DAC : (CONT_MODE ? SAMPLE : IDLE);
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        sc_nx       = state_nx == IDLE || state_nx == SAMPLE;
        comp_clk_nx = state_nx == COMP;
    end

    always_ff @(posedge CLK or negedge XRST) begin
        if (!XRST) begin
            COMP_CLK     <= 1'b0;
            SC           <= 1'b1;
            SDAC         <= '0;
            DOUT_SER     <= 1'b0;
            DOUT_SER_VLD <= 1'b0;
            RESULT       <= '0;
            RESULT_VLD   <= 1'b0;
            BUSY         <= 1'b0;
            OVERRUN      <= 1'b0;
        end else begin
            COMP_CLK     <= comp_clk_nx;
            SC           <= sc_nx;
            SDAC         <= sdac_nx;
            BUSY         <= state_nx != IDLE;
            DOUT_SER_VLD <= dec_edge;
            DOUT_SER     <= dec_edge ? COMP_OUT : DOUT_SER;
            // a finished code is dropped when the previous one is still pending
            OVERRUN      <= lsb_edge && RESULT_VLD && !RESULT_RDY;
            if (lsb_edge && (!RESULT_VLD || RESULT_RDY)) begin
                RESULT     <= code;
                RESULT_VLD <= 1'b1;
            end else if (RESULT_RDY) begin
                RESULT_VLD <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sar_ctrl_param.sv
// tb_sar_ctrl_param: scoreboard bench; stimulus queues expected codes/bits/edges, monitors compare DUT outputs
module tb_sar_ctrl_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic xrst, start, cont, rdy, cclk, sc, dout, dvld, vld, busy, ovr;
    logic [8:0] sdac;
    logic [7:0] result, vin;
    logic comp_out;
    assign comp_out = vin >= sdac[8:1];

    sar_ctrl_param u0 (
        .CLK(clk), .XRST(xrst), .START(start), .CONT_MODE(cont), .COMP_OUT(comp_out),
        .COMP_CLK(cclk), .SC(sc), .SDAC(sdac), .DOUT_SER(dout), .DOUT_SER_VLD(dvld),
        .RESULT(result), .RESULT_VLD(vld), .RESULT_RDY(rdy), .BUSY(busy), .OVERRUN(ovr)
    );

    logic b_xrst, b_start, b_cclk, b_sc, b_dout, b_dvld, b_vld, b_busy, b_ovr, b_comp_out;
    logic [12:0] b_sdac;
    logic [11:0] b_result, b_vin;
    assign b_comp_out = b_vin >= b_sdac[12:1];

    sar_ctrl_param #(.N_BITS(12), .PH_CYC(2), .SAMP_CYC(4)) u1 (
        .CLK(clk), .XRST(b_xrst), .START(b_start), .CONT_MODE(1'b0), .COMP_OUT(b_comp_out),
        .COMP_CLK(b_cclk), .SC(b_sc), .SDAC(b_sdac), .DOUT_SER(b_dout), .DOUT_SER_VLD(b_dvld),
        .RESULT(b_result), .RESULT_VLD(b_vld), .RESULT_RDY(1'b1), .BUSY(b_busy), .OVERRUN(b_ovr)
    );

    typedef struct { logic [15:0] code; int at; } exp_t;
    exp_t rq[$], brq[$];
    logic bq[$];
    int oq[$];
    int n_vec = 0, n_err = 0, cyc = 0, s, c0;
    int cc_cnt = 0, b_hi = 0, b_pulses = 0;
    logic vld_d = 1'b0, cc_d = 1'b0, b_vld_d = 1'b0, sdac0_bad = 1'b0, b_wbad = 1'b0, b_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic miss(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: DUT output with nothing expected at edge %0d", nm, cyc);
    endtask

    task automatic push_bits(input logic [7:0] c);
        for (int i = 7; i >= 0; i--) bq.push_back(c[i]);
    endtask

    task automatic run_conv(input logic [7:0] v);
        vin = v;
        s = cyc + 1;
        rq.push_back('{code: {8'h00, v}, at: s + 27});
        push_bits(v);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (vld && !vld_d) begin
            if (rq.size() == 0) miss("result");
            else begin
                e = rq.pop_front();
                chk("result", {24'h0, result}, {16'h0, e.code});
                chk("result_edge", cyc, e.at);
            end
        end
        if (dvld) begin
            if (bq.size() == 0) miss("dout_ser");
            else chk("dout_ser", {31'h0, dout}, {31'h0, bq.pop_front()});
        end
        if (ovr) begin
            if (oq.size() == 0) miss("overrun");
            else chk("overrun_edge", cyc, oq.pop_front());
        end
        if (cclk && !cc_d) cc_cnt = cc_cnt + 1;
        if (sdac[0]) sdac0_bad = 1'b1;
        vld_d = vld;
        cc_d = cclk;
    end

    always @(negedge clk) begin
        exp_t e;
        if (b_vld && !b_vld_d) begin
            if (brq.size() == 0) miss("b_result");
            else begin
                e = brq.pop_front();
                chk("b_result", {20'h0, b_result}, {16'h0, e.code});
                chk("b_result_edge", cyc, e.at);
            end
        end
        if (b_cclk) b_hi = b_hi + 1;
        else if (b_hi != 0) begin
            b_pulses = b_pulses + 1;
            if (b_hi != 2) b_wbad = 1'b1;
            b_hi = 0;
        end
        b_vld_d = b_vld;
    end

    initial begin
        int t;
        b_xrst = 1'b0; b_start = 1'b0; b_vin = 12'hABC;
        repeat (4) @(negedge clk);
        b_xrst = 1'b1;
        repeat (2) @(negedge clk);
        t = cyc + 1;
        brq.push_back('{code: 16'h0ABC, at: t + 78});
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        repeat (85) @(negedge clk);
        b_done = 1'b1;
    end

    initial begin
        xrst = 1'b0; start = 1'b0; cont = 1'b0; rdy = 1'b1; vin = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_sc", {31'h0, sc}, 1);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_sdac", {23'h0, sdac}, 0);
        chk("rst_result", {24'h0, result}, 0);
        chk("rst_vld", {31'h0, vld}, 0);
        chk("rst_cclk", {31'h0, cclk}, 0);
        chk("rst_dout", {30'h0, dout, dvld}, 0);
        chk("rst_ovr", {31'h0, ovr}, 0);
        xrst = 1'b1;
        repeat (2) @(negedge clk);

        // single conversion of 0xA5 with busy timing
        c0 = cc_cnt;
        vin = 8'hA5;
        s = cyc + 1;
        rq.push_back('{code: 16'h00A5, at: s + 27});
        push_bits(8'hA5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (26) @(negedge clk);
        chk("busy_mid", {31'h0, busy}, 1);
        repeat (2) @(negedge clk);
        chk("busy_done", {31'h0, busy}, 0);
        chk("comp_clk_pulses_a5", cc_cnt - c0, 8);
        repeat (2) @(negedge clk);

        // extremes
        c0 = cc_cnt;
        run_conv(8'h00);
        chk("comp_clk_pulses_00", cc_cnt - c0, 8);
        c0 = cc_cnt;
        run_conv(8'hFF);
        chk("comp_clk_pulses_ff", cc_cnt - c0, 8);

        // continuous mode with consumer stalled
        cont = 1'b1; rdy = 1'b0; vin = 8'h3C;
        s = cyc + 1;
        rq.push_back('{code: 16'h003C, at: s + 27});
        push_bits(8'h3C);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (27) @(negedge clk);
        vin = 8'h81;
        push_bits(8'h81);
        push_bits(8'h81);
        oq.push_back(s + 54);
        rq.push_back('{code: 16'h0081, at: s + 81});
        repeat (27) @(negedge clk);
        chk("result_held", {24'h0, result}, 32'h3C);
        chk("vld_held", {31'h0, vld}, 1);
        repeat (6) @(negedge clk);
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        chk("vld_accepted", {31'h0, vld}, 0);
        repeat (9) @(negedge clk);
        cont = 1'b0;
        repeat (12) @(negedge clk);
        chk("busy_after_cont", {31'h0, busy}, 0);
        rdy = 1'b1;
        repeat (3) @(negedge clk);

        // asynchronous reset mid-conversion
        vin = 8'hA5;
        bq.push_back(1'b1);
        bq.push_back(1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        #2 xrst = 1'b0;
        #1;
        chk("arst_sc", {31'h0, sc}, 1);
        chk("arst_busy", {31'h0, busy}, 0);
        chk("arst_sdac", {23'h0, sdac}, 0);
        chk("arst_result", {24'h0, result}, 0);
        chk("arst_vld_dvld_cclk", {29'h0, vld, dvld, cclk}, 0);
        repeat (2) @(negedge clk);
        xrst = 1'b1;
        repeat (3) @(negedge clk);
        run_conv(8'hA5);

        // START held high: back-to-back single shots
        start = 1'b1;
        s = cyc + 1;
        rq.push_back('{code: 16'h00A5, at: s + 27});
        rq.push_back('{code: 16'h00A5, at: s + 55});
        push_bits(8'hA5);
        push_bits(8'hA5);
        @(negedge clk);
        repeat (27) @(negedge clk);
        chk("idle_gap", {31'h0, busy}, 0);
        @(negedge clk);
        chk("restart", {31'h0, busy}, 1);
        start = 1'b0;
        repeat (29) @(negedge clk);
        chk("busy_after_b2b", {31'h0, busy}, 0);

        // START pulse while busy is ignored
        s = cyc + 1;
        rq.push_back('{code: 16'h00A5, at: s + 27});
        push_bits(8'hA5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("busy_ignored_start", {31'h0, busy}, 0);
        repeat (5) @(negedge clk);

        for (int i = 0; i < 200 && !b_done; i++) @(negedge clk);
        chk("b_done", {31'h0, b_done}, 1);
        chk("results_left", rq.size(), 0);
        chk("bits_left", bq.size(), 0);
        chk("overruns_left", oq.size(), 0);
        chk("b_results_left", brq.size(), 0);
        chk("sdac0_zero", {31'h0, sdac0_bad}, 0);
        chk("b_comp_clk_pulses", b_pulses, 12);
        chk("b_comp_clk_width", {31'h0, b_wbad}, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
